// File: rtl/msg_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : msg_scroller
//  Description : Scrolls a message of up to 16 ASCII characters across a
//                five-digit display window. The message is followed by five
//                blanks, so the visible sequence has period P = Len + 5.
//                The window rests at position 0 for DWELL_TICKS ticks. It then
//                advances one position per tick and wraps back to position 0.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TICK_DIV    : clock cycles per scroll tick (1 .. 2^26)
//    DWELL_TICKS : ticks held at window position 0 (1 .. 15)
//  Ports
//    Clk          in   1  rising-edge clock
//    Reset_n      in   1  synchronous active-low reset
//    Run          in   1  1 = scroll, 0 = freeze
//    WrEn         in   1  write WrData into buffer[WrAddr]
//    WrAddr       in   4  buffer index
//    WrData       in   8  ASCII code
//    LenWr        in   1  load message length (ignored unless LenData is 1..16)
//    LenData      in   5  new length
//    Char4..Char0 out  8  registered ASCII codes of the display, left to right
//    Wrap         out  1  one-cycle pulse when the window returns to position 0
//    State        out  2  00 STOP, 01 DWELL, 10 SCROLL
// ============================================================================
module msg_scroller #(
    parameter int TICK_DIV    = 25000000,
    parameter int DWELL_TICKS = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Run,
    input  logic       WrEn,
    input  logic [3:0] WrAddr,
    input  logic [7:0] WrData,
    input  logic       LenWr,
    input  logic [4:0] LenData,
    output logic [7:0] Char4,
    output logic [7:0] Char3,
    output logic [7:0] Char2,
    output logic [7:0] Char1,
    output logic [7:0] Char0,
    output logic       Wrap,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'b00,
        ST_DWELL  = 2'b01,
        ST_SCROLL = 2'b10
    } state_e;

    localparam logic [25:0] TICK_MAX   = 26'(TICK_DIV - 1);
    localparam logic [3:0]  DWELL_LAST = 4'(DWELL_TICKS - 1);
    localparam logic [7:0]  BLANK      = 8'h20;

    logic [7:0]  buf_q [16];
    logic [4:0]  len_q;
    logic [4:0]  pos_q;
    logic [25:0] presc_q;
    logic [3:0]  dwell_q;
    state_e      state_q;
    logic        wrap_evt_q;   // set on the edge where Pos returns to 0
    logic        wrap_q;       // delayed by one cycle to line up with the Char update
    logic [7:0]  chars_q [5];  // index 0 is the leftmost digit (Char4)
    logic [7:0]  chars_d [5];

    logic [5:0]  period;
    logic        tick;
    logic        len_valid;
    logic [4:0]  pos_inc;
    logic        pos_last;

    assign period    = {1'b0, len_q} + 6'd5;
    assign tick      = (state_q != ST_STOP) && (presc_q == TICK_MAX);
    assign len_valid = LenWr && (LenData != 5'd0) && (LenData <= 5'd16);
    assign pos_inc   = pos_q + 5'd1;
    assign pos_last  = ({1'b0, pos_inc} == period);

    // Window contents: seq[(Pos+k) mod P]. Pos < P and k < 5 <= P, so a
    // single conditional subtraction is enough for the modulo.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            logic [5:0] idx;
            idx = {1'b0, pos_q} + 6'(k);
            if (idx >= period) begin
                idx = idx - period;
            end
            chars_d[k] = (idx < {1'b0, len_q}) ? buf_q[idx[3:0]] : BLANK;
        end
    end

    // Message buffer.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= BLANK;
            end
            buf_q[0] <= 8'h48;
            buf_q[1] <= 8'h65;
            buf_q[2] <= 8'h6C;
            buf_q[3] <= 8'h6C;
            buf_q[4] <= 8'h6F;
        end else if (WrEn) begin
            buf_q[WrAddr] <= WrData;
        end
    end

    // Display registers: one cycle behind buffer, length and position.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            chars_q[0] <= 8'h48;
            chars_q[1] <= 8'h65;
            chars_q[2] <= 8'h6C;
            chars_q[3] <= 8'h6C;
            chars_q[4] <= 8'h6F;
        end else begin
            for (int k = 0; k < 5; k++) begin
                chars_q[k] <= chars_d[k];
            end
        end
    end

    // Control FSM. A valid length load has priority over Run and over any
    // tick in the same cycle. Run=0 has priority over a coincident tick.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            len_q      <= 5'd5;
            pos_q      <= 5'd0;
            presc_q    <= 26'd0;
            dwell_q    <= 4'd0;
            state_q    <= ST_STOP;
            wrap_evt_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_evt_q <= 1'b0;
            wrap_q     <= wrap_evt_q;
            if (len_valid) begin
                len_q   <= LenData;
                pos_q   <= 5'd0;
                presc_q <= 26'd0;
                dwell_q <= 4'd0;
                state_q <= Run ? ST_DWELL : ST_STOP;
            end else if (!Run) begin
                state_q <= ST_STOP;
                presc_q <= 26'd0;
                dwell_q <= 4'd0;
            end else begin
                case (state_q)
                    ST_STOP: begin
                        presc_q <= 26'd0;
                        dwell_q <= 4'd0;
                        state_q <= (pos_q == 5'd0) ? ST_DWELL : ST_SCROLL;
                    end
                    ST_DWELL: begin
                        presc_q <= tick ? 26'd0 : presc_q + 26'd1;
                        if (tick) begin
                            if (dwell_q == DWELL_LAST) begin
                                dwell_q <= 4'd0;
                                pos_q   <= 5'd1;
                                state_q <= ST_SCROLL;
                            end else begin
                                dwell_q <= dwell_q + 4'd1;
                            end
                        end
                    end
                    ST_SCROLL: begin
                        presc_q <= tick ? 26'd0 : presc_q + 26'd1;
                        if (tick) begin
                            if (pos_last) begin
                                pos_q      <= 5'd0;
                                dwell_q    <= 4'd0;
                                state_q    <= ST_DWELL;
                                wrap_evt_q <= 1'b1;
                            end else begin
                                pos_q <= pos_inc;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_STOP;
                        presc_q <= 26'd0;
                        dwell_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign Char4 = chars_q[0];
    assign Char3 = chars_q[1];
    assign Char2 = chars_q[2];
    assign Char1 = chars_q[3];
    assign Char0 = chars_q[4];
    assign Wrap  = wrap_q;
    assign State = state_q;

endmodule
`default_nettype wire

// File: tb/tb_msg_scroller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msg_scroller
//  Description : Directed bench for msg_scroller (TICK_DIV=2, DWELL_TICKS=1).
//                Stimulus queues the expected display, state and wrap for a
//                given cycle. A monitor compares them on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msg_scroller;

    localparam logic [39:0] HELLO = 40'h48656C6C6F;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Run;
    logic       WrEn;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       LenWr;
    logic [4:0] LenData;
    logic [7:0] Char4, Char3, Char2, Char1, Char0;
    logic       Wrap;
    logic [1:0] State;

    msg_scroller #(.TICK_DIV(2), .DWELL_TICKS(1)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Run     (Run),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .LenWr   (LenWr),
        .LenData (LenData),
        .Char4   (Char4),
        .Char3   (Char3),
        .Char2   (Char2),
        .Char1   (Char1),
        .Char0   (Char0),
        .Wrap    (Wrap),
        .State   (State)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [31:0]  cyc;
        logic [39:0]  ch;
        logic [1:0]   st;
        logic         w;
        logic [127:0] nm;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   wrap_cnt = 0;

    always @(posedge Clk) cyc++;

    // Monitor: every falling edge, pop and check all expectations due now.
    always @(negedge Clk) begin
        if (Wrap === 1'b1) wrap_cnt++;
        while (sb.size() > 0 && sb[0].cyc <= 32'(cyc)) begin
            exp_t e;
            e = sb.pop_front();
            n_tests++;
            if ({Char4, Char3, Char2, Char1, Char0} !== e.ch ||
                State !== e.st || Wrap !== e.w) begin
                n_fail++;
                $display("FAIL %0s: got chars=%h state=%b wrap=%b, expected chars=%h state=%b wrap=%b",
                         e.nm, {Char4, Char3, Char2, Char1, Char0}, State, Wrap,
                         e.ch, e.st, e.w);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Expectation for the outputs following the clock edge just passed.
    task automatic chk(input logic [127:0] nm, input logic [39:0] ch,
                       input logic [1:0] st, input logic w);
        exp_t e;
        e.cyc = 32'(cyc);
        e.ch  = ch;
        e.st  = st;
        e.w   = w;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    initial begin
        Reset_n = 1'b0; Run = 1'b0; WrEn = 1'b0; WrAddr = 4'd0; WrData = 8'd0;
        LenWr = 1'b0; LenData = 5'd0;
        step(2);
        Reset_n = 1'b1;
        chk("reset", HELLO, 2'b00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1); chk("idle", HELLO, 2'b00, 1'b0);
        end

        // Run from reset: dwell, scroll a full period, wrap.
        Run = 1'b1;
        step(1);  chk("dwell_entry", HELLO, 2'b01, 1'b0);
        step(2);  chk("scroll_lag", HELLO, 2'b10, 1'b0);
        step(1);  chk("pos1", 40'h656C6C6F20, 2'b10, 1'b0);
        step(2);  chk("pos2", 40'h6C6C6F2020, 2'b10, 1'b0);
        step(15); chk("pre_wrap", 40'h2048656C6C, 2'b01, 1'b0);
        step(1);  chk("wrap", HELLO, 2'b01, 1'b1);
        step(1);  chk("wrap_clear", HELLO, 2'b10, 1'b0);

        // Freeze at Pos=3, then resume.
        step(4);  Run = 1'b0;
        step(1);  chk("freeze", 40'h6C6F202020, 2'b00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1); chk("frozen", 40'h6C6F202020, 2'b00, 1'b0);
        end
        Run = 1'b1;
        step(1);  chk("resume", 40'h6C6F202020, 2'b10, 1'b0);
        step(2);  chk("resume_lag", 40'h6C6F202020, 2'b10, 1'b0);
        step(1);  chk("pos4", 40'h6F20202020, 2'b10, 1'b0);

        // Run dropped in the cycle a tick would occur: no advance.
        Run = 1'b0;
        step(2);  chk("tick_ignored", 40'h6F20202020, 2'b00, 1'b0);
        Run = 1'b1;
        step(4);  chk("pos5", 40'h2020202020, 2'b10, 1'b0);

        // Length load coinciding with a tick.
        LenWr = 1'b1; LenData = 5'd2;
        step(1);  LenWr = 1'b0;
        chk("lenwr_lag", 40'h2020202020, 2'b01, 1'b0);
        step(1);  chk("lenwr", 40'h4865202020, 2'b01, 1'b0);
        Run = 1'b0;
        step(1);  chk("stop_len2", 40'h4865202020, 2'b00, 1'b0);

        // Illegal lengths are ignored.
        LenWr = 1'b1; LenData = 5'd0;
        step(1);  LenData = 5'd17;
        step(1);  LenWr = 1'b0;
        chk("bad_len0", 40'h4865202020, 2'b00, 1'b0);
        step(1);  chk("bad_len17", 40'h4865202020, 2'b00, 1'b0);

        // Buffer writes: visible, hidden, and together with a length load.
        WrEn = 1'b1; WrAddr = 4'd1; WrData = 8'h41;
        step(1);  chk("wr_lag", 40'h4865202020, 2'b00, 1'b0);
        WrAddr = 4'd3; WrData = 8'h5A;
        step(1);  chk("wr_a1", 40'h4841202020, 2'b00, 1'b0);
        WrAddr = 4'd2; WrData = 8'h42; LenWr = 1'b1; LenData = 5'd4;
        step(1);  WrEn = 1'b0; LenWr = 1'b0;
        chk("wr_hidden", 40'h4841202020, 2'b00, 1'b0);
        step(1);  chk("len4_wr", 40'h4841425A20, 2'b00, 1'b0);

        // Reset in the middle of a scroll beats Run, WrEn and LenWr.
        Run = 1'b1;
        step(1);  chk("run_len4", 40'h4841425A20, 2'b01, 1'b0);
        step(3);  chk("len4_pos1", 40'h41425A2020, 2'b10, 1'b0);
        Reset_n = 1'b0; WrEn = 1'b1; WrAddr = 4'd0; WrData = 8'h00;
        LenWr = 1'b1; LenData = 5'd3;
        step(1);  chk("mid_reset", HELLO, 2'b00, 1'b0);
        Reset_n = 1'b1; WrEn = 1'b0; LenWr = 1'b0;
        step(1);  chk("post_reset", HELLO, 2'b01, 1'b0);
        step(3);  chk("post_reset_pos1", 40'h656C6C6F20, 2'b10, 1'b0);

        step(2);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        end
        n_tests++;
        if (wrap_cnt != 1) begin
            n_fail++;
            $display("FAIL wrap_pulses: got %0d, expected 1", wrap_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/msg_scroller.md
MSG_SCROLLER -- requirements
Module: msg_scroller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000; clock cycles per scroll tick; legal range 1..2^26.
REQ-002 SHALL have parameter DWELL_TICKS, default 2; ticks held at window position 0; legal range 1..15.
REQ-003 SHALL have port Clk, input, 1 bit; the only clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit; synchronous, active-low reset.
REQ-005 SHALL have port Run, input, 1 bit; 1 = scroll, 0 = freeze.
REQ-006 SHALL have port WrEn, input, 1 bit; writes one character into the message buffer.
REQ-007 SHALL have port WrAddr, input, 4 bits; buffer index 0..15.
REQ-008 SHALL have port WrData, input, 8 bits; ASCII code to write.
REQ-009 SHALL have port LenWr, input, 1 bit; loads the message length.
REQ-010 SHALL have port LenData, input, 5 bits; new length, legal 1..16.
REQ-011 SHALL have ports Char4, Char3, Char2, Char1, Char0, output, 8 bits each; ASCII codes for the five display digits, left to right, each feeding one ASCII-to-7-segment decoder.
REQ-012 SHALL have port Wrap, output, 1 bit; one-cycle pulse when the window returns to position 0.
REQ-013 SHALL have port State, output, 2 bits; 00 STOP, 01 DWELL, 10 SCROLL.

Function
REQ-014 SHALL hold a 16x8 message buffer and a length register Len; period P = Len+5.
REQ-015 SHALL define the virtual sequence seq[i]: buffer[i] for i<Len, 0x20 (blank) for Len<=i<P.
REQ-016 SHALL hold window position Pos, range 0..P-1; Char4 = seq[Pos], Char3 = seq[(Pos+1) mod P], through Char0 = seq[(Pos+4) mod P].
REQ-017 SHALL register Char4..Char0, so they reflect buffer, Len and Pos exactly one cycle after any change to those.
REQ-018 SHALL run a prescaler 0..TICK_DIV-1 only in DWELL or SCROLL; a tick occurs in the cycle the prescaler equals TICK_DIV-1, and the prescaler then wraps to 0.
REQ-019 SHALL clear the prescaler and the dwell count in STOP.
REQ-020 SHALL go from STOP, when Run=1, to DWELL if Pos=0, otherwise to SCROLL.
REQ-021 SHALL count ticks in DWELL; on the DWELL_TICKS-th tick, Pos becomes 1 and the state becomes SCROLL.
REQ-022 SHALL, on each tick in SCROLL, set Pos to (Pos+1) mod P; when the new Pos is 0, it SHALL assert Wrap for exactly one cycle (aligned with the Char update) and go to DWELL.
REQ-023 SHALL, when Run=0 in any state, go to STOP on the next edge with Pos held; a tick coinciding with Run=0 SHALL be ignored.
REQ-024 SHALL, on WrEn=1, write WrData to buffer[WrAddr], including addresses >= Len (stored, not displayed); Pos and the state are unaffected.
REQ-025 SHALL, on LenWr=1 with LenData in 1..16, load Len, set Pos to 0, clear the prescaler and dwell count, and set the state to DWELL if Run=1, otherwise STOP.
REQ-026 SHALL ignore LenWr with LenData = 0 or > 16 entirely (no Len, Pos or state change).
REQ-027 SHALL give a valid LenWr priority over a simultaneous tick (no Pos advance, no Wrap); WrEn and LenWr in the same cycle SHALL both take effect.
REQ-028 SHALL NOT assert Wrap due to a LenWr or reset.

Reset
REQ-029 SHALL, with Reset_n=0 at a clock edge, set buffer[0..4] to 0x48 0x65 0x6C 0x6C 0x6F ("Hello"), buffer[5..15] to 0x20, Len=5, Pos=0, prescaler=0, dwell count=0, State=STOP, Wrap=0, and Char4..Char0 to 0x48 0x65 0x6C 0x6C 0x6F.
REQ-030 SHALL give reset priority over Run, WrEn and LenWr, including mid-scroll; the first post-reset cycle SHALL obey REQ-020.

Verification (TICK_DIV=2, DWELL_TICKS=1 unless stated)
REQ-031 SHALL cover reset release with Run=0: outputs 48 65 6C 6C 6F, State=00, unchanged for 100 cycles.
REQ-032 SHALL cover Run=1 from reset: State=01; first tick -> Pos=1, Chars 65 6C 6C 6F 20; after 9 more ticks Pos=0, Chars 48 65 6C 6C 6F, Wrap high exactly 1 cycle, State=01.
REQ-033 SHALL cover Run dropped at Pos=3 for 20 cycles: Chars frozen at 6C 6F 20 20 20, State=00; Run=1 -> State=10, next tick Pos=4.
REQ-034 SHALL cover LenWr LenData=2 mid-scroll coinciding with a tick: Pos=0, Chars 48 65 20 20 20, no Wrap, State=01; LenData=0 or 17 -> no change.
REQ-035 SHALL cover WrEn addr 1 data 0x41 while displayed: Char3=0x41 one cycle later, Pos unchanged.
REQ-036 SHALL cover Reset_n=0 asserted mid-SCROLL: next cycle all REQ-029 values.
